// File: rtl/audio_stream_buffer.sv
// Multi-channel audio FIFO buffer between ADC source and DAC sink streams.
// Ports: clock/reset(async active-low), adc_* in stream, dac_* out stream,
//   mute/atten write-time processing, overrun/ovr_clr sticky drop flags,
//   activity LED stretchers, peak/peak_clr meter (AUDIO_STREAM_BUFFER_PEAK_METER_EN).
module audio_stream_buffer #(
    parameter int NCH          = 2,
    parameter int DW           = 32,
    parameter int DEPTH        = 8,
    parameter int DROP_ON_FULL = 0,
    parameter int STRETCH      = 2500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH*DW-1:0] adc_data,
    input  logic [NCH-1:0]    adc_valid,
    output logic [NCH-1:0]    adc_ready,
    output logic [NCH*DW-1:0] dac_data,
    output logic [NCH-1:0]    dac_valid,
    input  logic [NCH-1:0]    dac_ready,
    input  logic [NCH-1:0]    mute,
    input  logic [4:0]        atten,
    output logic [NCH-1:0]    overrun,
    input  logic              ovr_clr,
    output logic [NCH-1:0]    activity,
    output logic [NCH*DW-1:0] peak,
    input  logic              peak_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STRETCH + 1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [AW:0]   wr_ptr;
        logic [AW:0]   rd_ptr;
        logic          full;
        logic          empty;
        logic          accept;
        logic          push;
        logic          pop;
        logic          ovr_q;
        logic [DW-1:0] sample_in;
        logic [DW-1:0] processed;
        logic [DW-1:0] head;
        logic [SW-1:0] act_cnt;

        assign empty = (wr_ptr == rd_ptr);
        assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

        // Drop mode always accepts; the write is suppressed when full.
        assign adc_ready[c] = reset && ((DROP_ON_FULL != 0) || !full);
        assign accept       = adc_valid[c] & adc_ready[c];
        assign push         = accept & !full;
        assign pop          = !empty & dac_ready[c];

        assign head         = mem[rd_ptr[AW-1:0]];
        assign dac_valid[c] = !empty;
        assign dac_data[c*DW +: DW] = empty ? '0 : head;

        assign sample_in = adc_data[c*DW +: DW];

        always_comb begin
            processed = '0;
            if (mute[c]) begin
                processed = '0;
            end else if (32'(atten) >= DW) begin
                processed = {DW{sample_in[DW-1]}};
            end else begin
                processed = $signed(sample_in) >>> atten;
            end
        end

        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= processed;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                ovr_q   <= 1'b0;
                act_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                // A drop in the same cycle as a clear keeps the flag set.
                if (accept && full) begin
                    ovr_q <= 1'b1;
                end else if (ovr_clr) begin
                    ovr_q <= 1'b0;
                end
                if (pop) begin
                    act_cnt <= SW'(STRETCH - 1);
                end else if (act_cnt != '0) begin
                    act_cnt <= act_cnt - 1'b1;
                end
            end
        end

        assign overrun[c]  = ovr_q;
        assign activity[c] = (act_cnt != '0);

`ifdef AUDIO_STREAM_BUFFER_PEAK_METER_EN
        logic [DW-1:0] mag;
        logic [DW-1:0] peak_q;

        // The most negative value has no positive twin; saturate it.
        always_comb begin
            mag = head;
            if (head[DW-1]) begin
                if (head == {1'b1, {(DW-1){1'b0}}}) begin
                    mag = {1'b0, {(DW-1){1'b1}}};
                end else begin
                    mag = -head;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                peak_q <= '0;
            end else if (peak_clr) begin
                peak_q <= pop ? mag : '0;
            end else if (pop && (mag > peak_q)) begin
                peak_q <= mag;
            end
        end

        assign peak[c*DW +: DW] = peak_q;
`else
        assign peak[c*DW +: DW] = '0;
`endif
    end

`ifndef AUDIO_STREAM_BUFFER_PEAK_METER_EN
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
`endif

endmodule

// File: tb/tb_audio_stream_buffer.sv
// Directed testbench for audio_stream_buffer.
// Drives a back-pressure instance and a drop-on-full instance.
module tb_audio_stream_buffer;

    logic        clock;
    logic        rst_n;
    logic [1:0]  mute;
    logic [4:0]  atten;
    logic        ovr_clr;
    logic        peak_clr;

    logic [63:0] bp_adc_data, dr_adc_data;
    logic [1:0]  bp_adc_valid, dr_adc_valid;
    logic [1:0]  bp_adc_ready, dr_adc_ready;
    logic [63:0] bp_dac_data, dr_dac_data;
    logic [1:0]  bp_dac_valid, dr_dac_valid;
    logic [1:0]  bp_dac_ready, dr_dac_ready;
    logic [1:0]  bp_overrun, dr_overrun;
    logic [1:0]  bp_activity, dr_activity;
    logic [63:0] bp_peak, dr_peak;

    int tests = 0;
    int fails = 0;

    audio_stream_buffer #(
        .NCH(2), .DW(32), .DEPTH(8), .DROP_ON_FULL(0), .STRETCH(4)
    ) u_bp (
        .clock(clock), .reset(rst_n),
        .adc_data(bp_adc_data), .adc_valid(bp_adc_valid),
        .adc_ready(bp_adc_ready), .dac_data(bp_dac_data),
        .dac_valid(bp_dac_valid), .dac_ready(bp_dac_ready),
        .mute(mute), .atten(atten), .overrun(bp_overrun),
        .ovr_clr(ovr_clr), .activity(bp_activity),
        .peak(bp_peak), .peak_clr(peak_clr)
    );

    audio_stream_buffer #(
        .NCH(2), .DW(32), .DEPTH(8), .DROP_ON_FULL(1), .STRETCH(4)
    ) u_dr (
        .clock(clock), .reset(rst_n),
        .adc_data(dr_adc_data), .adc_valid(dr_adc_valid),
        .adc_ready(dr_adc_ready), .dac_data(dr_dac_data),
        .dac_valid(dr_dac_valid), .dac_ready(dr_dac_ready),
        .mute(mute), .atten(atten), .overrun(dr_overrun),
        .ovr_clr(ovr_clr), .activity(dr_activity),
        .peak(dr_peak), .peak_clr(peak_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mute = '0; atten = '0; ovr_clr = 1'b0; peak_clr = 1'b0;
        bp_adc_data = '0; bp_adc_valid = '0; bp_dac_ready = '0;
        dr_adc_data = '0; dr_adc_valid = '0; dr_dac_ready = '0;
        repeat (3) tick();
        tests++;
        if ({bp_adc_ready, dr_adc_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_adc_ready got %b/%b want 00/00", bp_adc_ready, dr_adc_ready);
        end
        tests++;
        if ({bp_dac_valid, dr_dac_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_dac_valid got %b/%b want 00/00", bp_dac_valid, dr_dac_valid);
        end
        tests++;
        if (bp_dac_data !== 64'h0 || dr_dac_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_dac_data got %h/%h want 0", bp_dac_data, dr_dac_data);
        end
        tests++;
        if ({bp_overrun, dr_overrun, bp_activity, dr_activity} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags got %b%b%b%b want 0", bp_overrun, dr_overrun, bp_activity, dr_activity);
        end
        tests++;
        if (bp_peak !== 64'h0 || dr_peak !== 64'h0) begin
            fails++;
            $display("FAIL reset_peak got %h/%h want 0", bp_peak, dr_peak);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if ({bp_adc_ready, dr_adc_ready} !== 4'b1111) begin
            fails++;
            $display("FAIL post_reset_ready got %b/%b want 11/11", bp_adc_ready, dr_adc_ready);
        end
    endtask

    task automatic test_first_push();
        bp_adc_data = {32'h0, 32'h0000_1234};
        bp_adc_valid = 2'b01;
        tick();
        bp_adc_valid = 2'b00;
        tests++;
        if (bp_dac_valid !== 2'b01) begin
            fails++;
            $display("FAIL first_valid got %b want 01", bp_dac_valid);
        end
        tests++;
        if (bp_dac_data !== 64'h0000_0000_0000_1234) begin
            fails++;
            $display("FAIL first_data got %h want 0000000000001234", bp_dac_data);
        end
        bp_dac_ready = 2'b01;
        tick();
        bp_dac_ready = 2'b00;
        tests++;
        if (bp_dac_valid !== 2'b00) begin
            fails++;
            $display("FAIL first_drain got %b want 00", bp_dac_valid);
        end
        tests++;
        if (bp_activity !== 2'b01) begin
            fails++;
            $display("FAIL activity_on got %b want 01", bp_activity);
        end
        repeat (3) tick();
        tests++;
        if (bp_activity !== 2'b00) begin
            fails++;
            $display("FAIL activity_off got %b want 00", bp_activity);
        end
    endtask

    task automatic test_fill_backpressure();
        int nxt;
        int got;
        logic acc;
        logic popv;
        logic [31:0] popd;
        for (int i = 1; i <= 8; i++) begin
            bp_adc_data = {32'h0, 32'(i)};
            bp_adc_valid = 2'b01;
            tick();
        end
        bp_adc_valid = 2'b00;
        tests++;
        if (bp_adc_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL bp_full_ready got %b want 0", bp_adc_ready[0]);
        end
        nxt = 9;
        got = 0;
        bp_dac_ready = 2'b01;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            bp_adc_valid[0] = (nxt <= 10);
            bp_adc_data = {32'h0, 32'(nxt)};
            acc = bp_adc_valid[0] & bp_adc_ready[0];
            popv = bp_dac_valid[0];
            popd = bp_dac_data[31:0];
            tick();
            if (acc) nxt++;
            if (popv) begin
                tests++;
                if (popd !== 32'(got + 1)) begin
                    fails++;
                    $display("FAIL bp_order[%0d] got %h want %h", got, popd, got + 1);
                end
                got++;
            end
        end
        bp_adc_valid = 2'b00;
        bp_dac_ready = 2'b00;
        tests++;
        if (got != 10) begin
            fails++;
            $display("FAIL bp_drain_count got %0d want 10", got);
        end
        tests++;
        if (bp_overrun !== 2'b00) begin
            fails++;
            $display("FAIL bp_overrun got %b want 00", bp_overrun);
        end
    endtask

    task automatic test_fill_drop();
        logic ready_lo;
        ready_lo = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            dr_adc_data = {32'h0, 32'(i)};
            dr_adc_valid = 2'b01;
            if (dr_adc_ready[0] !== 1'b1) ready_lo = 1'b1;
            tick();
        end
        dr_adc_valid = 2'b00;
        tests++;
        if (ready_lo) begin
            fails++;
            $display("FAIL dr_ready got 0 want 1");
        end
        tests++;
        if (dr_overrun !== 2'b01) begin
            fails++;
            $display("FAIL dr_overrun_set got %b want 01", dr_overrun);
        end
        dr_dac_ready = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tests++;
            if (dr_dac_valid[0] !== 1'b1 || dr_dac_data[31:0] !== 32'(i)) begin
                fails++;
                $display("FAIL dr_order[%0d] got %b/%h want 1/%h", i, dr_dac_valid[0], dr_dac_data[31:0], i);
            end
            tick();
        end
        dr_dac_ready = 2'b00;
        tests++;
        if (dr_dac_valid !== 2'b00) begin
            fails++;
            $display("FAIL dr_lost got %b want 00", dr_dac_valid);
        end
        tests++;
        if (dr_overrun !== 2'b01) begin
            fails++;
            $display("FAIL dr_overrun_sticky got %b want 01", dr_overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tests++;
        if (dr_overrun !== 2'b00) begin
            fails++;
            $display("FAIL dr_overrun_clr got %b want 00", dr_overrun);
        end
    endtask

    task automatic test_processing();
        logic [31:0] vin  [4];
        logic [4:0]  vat  [4];
        logic        vmu  [4];
        logic [31:0] vexp [4];
        vin[0] = 32'hFFFF_0000; vat[0] = 5'd4;  vmu[0] = 1'b0; vexp[0] = 32'hFFFF_F000;
        vin[1] = 32'h8000_0000; vat[1] = 5'd31; vmu[1] = 1'b0; vexp[1] = 32'hFFFF_FFFF;
        vin[2] = 32'h1234_5678; vat[2] = 5'd0;  vmu[2] = 1'b1; vexp[2] = 32'h0000_0000;
        vin[3] = 32'h7FFF_FFFF; vat[3] = 5'd31; vmu[3] = 1'b0; vexp[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            atten = vat[i];
            mute = {1'b0, vmu[i]};
            bp_adc_data = {32'h0, vin[i]};
            bp_adc_valid = 2'b01;
            tick();
            bp_adc_valid = 2'b00;
            atten = '0;
            mute = '0;
            tests++;
            if (bp_dac_data[31:0] !== vexp[i]) begin
                fails++;
                $display("FAIL proc[%0d] got %h want %h", i, bp_dac_data[31:0], vexp[i]);
            end
            bp_dac_ready = 2'b01;
            tick();
            bp_dac_ready = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] popd;
        logic [31:0] want;
        for (int i = 0; i < 7; i++) begin
            bp_adc_data = {32'h0, 32'(100 + i)};
            bp_adc_valid = 2'b01;
            q.push_back(32'(100 + i));
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            bp_adc_data = {32'h0, 32'(200 + k)};
            bp_adc_valid = 2'b01;
            bp_dac_ready = 2'b01;
            popd = bp_dac_data[31:0];
            tick();
            want = q.pop_front();
            q.push_back(32'(200 + k));
            tests++;
            if (popd !== want) begin
                fails++;
                $display("FAIL b2b[%0d] got %h want %h", k, popd, want);
            end
        end
        bp_adc_valid = 2'b00;
        bp_dac_ready = 2'b00;
        tests++;
        if (bp_adc_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_not_full got %b want 1", bp_adc_ready[0]);
        end
        bp_adc_data = {32'h0, 32'hDEAD};
        bp_adc_valid = 2'b01;
        tick();
        bp_adc_valid = 2'b00;
        tests++;
        if (bp_adc_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_occ7 got ready %b want 0", bp_adc_ready[0]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bp_dac_valid !== 2'b00 || bp_adc_ready !== 2'b00) begin
            fails++;
            $display("FAIL midreset got %b/%b want 00/00", bp_dac_valid, bp_adc_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (bp_dac_valid !== 2'b00 || bp_dac_data !== 64'h0) begin
            fails++;
            $display("FAIL postreset_empty got %b/%h want 00/0", bp_dac_valid, bp_dac_data);
        end
    endtask

    task automatic test_peak();
`ifdef AUDIO_STREAM_BUFFER_PEAK_METER_EN
        logic [31:0] vin  [3];
        logic [31:0] vexp [3];
        vin[0] = 32'h0000_0100; vexp[0] = 32'h0000_0100;
        vin[1] = 32'hFFFF_FE00; vexp[1] = 32'h0000_0200;
        vin[2] = 32'h8000_0000; vexp[2] = 32'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            bp_adc_data = {32'h0, vin[i]};
            bp_adc_valid = 2'b01;
            tick();
        end
        bp_adc_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            bp_dac_ready = 2'b01;
            tick();
            bp_dac_ready = 2'b00;
            tests++;
            if (bp_peak[31:0] !== vexp[i]) begin
                fails++;
                $display("FAIL peak[%0d] got %h want %h", i, bp_peak[31:0], vexp[i]);
            end
        end
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        tests++;
        if (bp_peak !== 64'h0) begin
            fails++;
            $display("FAIL peak_clr got %h want 0", bp_peak);
        end
`else
        bp_adc_data = {32'h0, 32'h8000_0000};
        bp_adc_valid = 2'b01;
        tick();
        bp_adc_valid = 2'b00;
        bp_dac_ready = 2'b01;
        tick();
        bp_dac_ready = 2'b00;
        tick();
        tests++;
        if (bp_peak !== 64'h0 || dr_peak !== 64'h0) begin
            fails++;
            $display("FAIL peak_off got %h/%h want 0", bp_peak, dr_peak);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_backpressure();
        test_fill_drop();
        test_processing();
        test_back_to_back();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_stream_buffer.md
Name: audio_stream_buffer

Overview:
- Parametrised successor to the direct ADC-to-DAC audio path. It sits between the audio_config ADC source and DAC sink streaming ports.
- Provides NCH independent channels, each with a DEPTH-entry FIFO, mute, arithmetic attenuation, a selectable full-handling mode, sticky overrun flags and LED activity stretchers.
- Replaces the purely combinational valid/ready tie-off with registered buffering, so DAC back-pressure no longer loses samples.

Parameters:
- NCH, 2, number of audio channels (2 = left/right).
- DW, 32, sample width in bits, two's complement.
- DEPTH, 8, FIFO entries per channel; must be a power of 2, at least 2.
- DROP_ON_FULL, 0, 0 = back-pressure the ADC when full; 1 = always accept and discard when full.
- STRETCH, 2500000, activity LED hold time in clock cycles (50 ms at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- adc_data  in  NCH*DW  channel c at bits [c*DW +: DW].
- adc_valid  in  NCH  per-channel source valid.
- adc_ready  out  NCH  per-channel source ready.
- dac_data  out  NCH*DW  per-channel head-of-FIFO sample.
- dac_valid  out  NCH  per-channel sink valid.
- dac_ready  in  NCH  per-channel sink ready.
- mute  in  NCH  per-channel mute, sampled at write time.
- atten  in  5  global right-shift amount, sampled at write time.
- overrun  out  NCH  sticky sample-dropped flag.
- ovr_clr  in  1  clears all overrun flags.
- activity  out  NCH  stretched DAC-handshake indicator for LEDs.
- peak  out  NCH*DW  peak magnitude; only meaningful with the optional feature.
- peak_clr  in  1  clears peak registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, counters, overrun, activity and peak go to 0.
  - adc_ready=0 and dac_valid=0 while reset is held.
  - dac_data=0 while the FIFO is empty.
- Channels are fully independent; no cross-channel alignment.
- Push: adc_valid[c] & adc_ready[c] on a rising edge writes processed(adc_data[c]).
- Pop: dac_valid[c] & dac_ready[c] advances the read pointer.
- FIFO is show-ahead:
  - dac_valid[c] = !empty[c].
  - dac_data[c] = head entry.
  - Latency: sample pushed at edge N gives dac_valid=1 from cycle N+1.
- adc_ready:
  - DROP_ON_FULL=0: adc_ready[c] = !full[c] (combinational from registered state only; never depends on adc_valid).
  - DROP_ON_FULL=1: adc_ready[c]=1 out of reset. A push while full leaves the FIFO unchanged and sets overrun[c].
- overrun[c] is sticky until ovr_clr=1. Set has priority over clear in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - Full: MSBs differ, rest equal.
  - Empty: pointers equal.
- Simultaneous push and pop:
  - When not full/empty: occupancy unchanged, both pointers advance.
  - Full: only a pop can occur; in DROP mode the incoming push is dropped and flagged even if a pop fires that cycle.
  - Empty: the push succeeds; no pop since dac_valid=0.
- processed(x):
  - mute[c]=1 gives 0.
  - Otherwise arithmetic right shift of x by atten; atten >= DW gives the sign fill (0 or all-ones).
- activity[c]:
  - Reloads a counter to STRETCH-1 on each DAC handshake, decrements to 0.
  - activity[c] = (counter != 0).
- A mid-stream reset discards all buffered samples; there is no partial-sample state.

Optional Feature:
- Macro: AUDIO_STREAM_BUFFER_PEAK_METER_EN.
- Defined:
  - peak[c] latches the maximum of |sample| over DAC handshakes; |most-negative| saturates to 2^(DW-1)-1.
  - Registered, updates the cycle after the handshake.
  - peak_clr zeroes it; a handshake in the same cycle loads that sample's magnitude.
- Undefined: peak is tied to 0 and peak_clr is ignored; no peak logic is synthesised.

Test Plan:
- Reset, then push 0x00001234 on ch0 with dac_ready=0 -> dac_valid[0]=1 next cycle, dac_data[0]=0x00001234; ch1 dac_valid stays 0.
- DROP_ON_FULL=0, DEPTH=8, dac_ready=0, push 10 samples -> adc_ready[0]=0 after the 8th; release dac_ready -> samples 1..8 in order, then 9 and 10 once re-accepted; overrun=0.
- DROP_ON_FULL=1, same stimulus -> adc_ready stays 1; samples 9 and 10 are lost; overrun[0]=1 until ovr_clr pulse, then 0.
- atten=4 and input 0xFFFF0000 -> output 0xFFFFF000; atten=31 and input 0x80000000 -> 0xFFFFFFFF; mute=1 -> 0x00000000.
- With FIFO at 7/8 entries, push and pop in the same cycle repeatedly -> occupancy holds at 7, order preserved; then assert reset mid-stream -> dac_valid=0 immediately, FIFO empty afterwards.
- PEAK_METER_EN defined, pop samples 0x00000100, 0xFFFFFE00, 0x80000000 -> peak = 0x100, then 0x200, then 0x7FFFFFFF; peak_clr -> 0.
